// File: rtl/ctrl_pkg.sv
// Shared definitions for the frame decoder: FSM encoding, header field layout
// and engine-target helpers.
package ctrl_pkg;

  localparam int NTGT    = 3;
  localparam int TGT_MSB = 7;
  localparam int TGT_LSB = 6;
  localparam int OP_LSB  = 4;

  localparam logic [1:0] TGT_INVALID = 2'd3;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    SRC   = 2'd1,
    DST   = 2'd2,
    ISSUE = 2'd3
  } state_t;

  // One-hot engine select; the invalid target maps to no engine at all.
  function automatic logic [NTGT-1:0] tgt_onehot(input logic [1:0] tgt);
    tgt_onehot = '0;
    if (tgt != TGT_INVALID) tgt_onehot[tgt] = 1'b1;
  endfunction

endpackage

// File: rtl/engine_busy_tracker.sv
// Per-engine busy flags: set on request handshake, cleared by completion pulses,
// which are turned into registered one-cycle acks.
module engine_busy_tracker
  import ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            issue,
  input  logic [1:0]      issue_tgt,
  input  logic [NTGT-1:0] done_in,
  output logic [NTGT-1:0] busy,
  output logic [NTGT-1:0] ack_out
);

  logic [NTGT-1:0] set_vec;
  logic [NTGT-1:0] clr_vec;

  // A completion only counts for an engine that actually holds a request.
  always_comb begin
    set_vec = issue ? tgt_onehot(issue_tgt) : '0;
    clr_vec = done_in & busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      ack_out <= '0;
    end else begin
      busy    <= (busy & ~clr_vec) | set_vec;
      ack_out <= clr_vec;
    end
  end

endmodule

// File: rtl/bus_frame_decoder.sv
// Reassembles byte-serial command frames into a parallel engine request.
// Optional idle timeout inside a frame is enabled with `define FRAME_TIMEOUT_EN.
//
// Handshakes: a byte moves when data_bus_valid && bus_ready; a request moves
// when req_valid && req_ready. A raised valid is never withdrawn before the
// matching ready, and the req_* payload is held constant while it waits.
module bus_frame_decoder
  import ctrl_pkg::*;
#(
  parameter int ADDRW          = 24,
  parameter int OPCODEW        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data_bus_in,
  input  logic               data_bus_valid,
  output logic               bus_ready,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [1:0]         req_target,
  output logic [OPCODEW-1:0] req_opcode,
  output logic [ADDRW-1:0]   req_src_addr,
  output logic [ADDRW-1:0]   req_dst_addr,
  input  logic [NTGT-1:0]    done_in,
  output logic [NTGT-1:0]    ack_out,
  output logic               frame_err,
  output logic [1:0]         state_dbg
);

  localparam int ABYTES = ADDRW / 8;
  localparam int CNTW   = (ABYTES > 1) ? $clog2(ABYTES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ABYTES - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CNTW-1:0] cnt;
  logic [NTGT-1:0] busy;
  logic            xfer;
  logic            issue;
  logic            timeout_hit;

  assign bus_ready = (state != ISSUE);
  assign xfer      = data_bus_valid && bus_ready;
  assign issue     = req_valid && req_ready;
  assign state_dbg = state;

`ifdef FRAME_TIMEOUT_EN
  localparam int IDLEW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [IDLEW-1:0] idle_cnt;
  logic             in_frame;

  assign in_frame    = (state == SRC) || (state == DST);
  assign timeout_hit = in_frame && !data_bus_valid &&
                       (idle_cnt == IDLEW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!in_frame || data_bus_valid || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  // No timeout hardware: a partial frame simply waits for its next byte.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HDR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    frame_err = 1'b0;
    case (state)
      HDR: begin
        if (data_bus_valid) state_nxt = SRC;
      end
      SRC: begin
        if (data_bus_valid && (cnt == CNT_LAST)) begin
          state_nxt = DST;
        end else if (timeout_hit) begin
          state_nxt = HDR;
          frame_err = 1'b1;
        end
      end
      DST: begin
        if (data_bus_valid && (cnt == CNT_LAST)) begin
          state_nxt = ISSUE;
        end else if (timeout_hit) begin
          state_nxt = HDR;
          frame_err = 1'b1;
        end
      end
      ISSUE: begin
        // Invalid target: the frame is already fully consumed, just drop it.
        if (req_target == TGT_INVALID) begin
          frame_err = 1'b1;
          state_nxt = HDR;
        end else begin
          req_valid = ((busy & tgt_onehot(req_target)) == '0);
          if (req_valid && req_ready) state_nxt = HDR;
        end
      end
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      req_target   <= '0;
      req_opcode   <= '0;
      req_src_addr <= '0;
      req_dst_addr <= '0;
    end else if (timeout_hit) begin
      cnt <= '0;
    end else if (xfer) begin
      case (state)
        HDR: begin
          req_target <= data_bus_in[TGT_MSB:TGT_LSB];
          req_opcode <= data_bus_in[OP_LSB +: OPCODEW];
          cnt        <= '0;
        end
        SRC: begin
          req_src_addr <= (req_src_addr << 8) | ADDRW'(data_bus_in);
          cnt          <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        DST: begin
          req_dst_addr <= (req_dst_addr << 8) | ADDRW'(data_bus_in);
          cnt          <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  engine_busy_tracker u_busy (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .issue_tgt (req_target),
    .done_in   (done_in),
    .busy      (busy),
    .ack_out   (ack_out)
  );

endmodule

// File: tb/tb_bus_frame_decoder.sv
// Bench for bus_frame_decoder: table-driven frames, hand-written multi-cycle
// sequences, then randomized traffic scored against a transaction-level model.
module tb_bus_frame_decoder;

  localparam int ADDRW          = 24;
  localparam int OPCODEW        = 2;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int AB             = ADDRW / 8;
  localparam int REQW           = 2 + OPCODEW + 2 * ADDRW;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         data_bus_in;
  logic               data_bus_valid;
  logic               bus_ready;
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_target;
  logic [OPCODEW-1:0] req_opcode;
  logic [ADDRW-1:0]   req_src_addr;
  logic [ADDRW-1:0]   req_dst_addr;
  logic [2:0]         done_in;
  logic [2:0]         ack_out;
  logic               frame_err;
  logic [1:0]         state_dbg;

  bus_frame_decoder #(
    .ADDRW(ADDRW), .OPCODEW(OPCODEW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .data_bus_in(data_bus_in), .data_bus_valid(data_bus_valid),
    .bus_ready(bus_ready), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_opcode(req_opcode), .req_src_addr(req_src_addr),
    .req_dst_addr(req_dst_addr), .done_in(done_in), .ack_out(ack_out),
    .frame_err(frame_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every task starts and ends at a drive point: 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_bus_valid = 1'b0; data_bus_in = 8'h00; req_ready = 1'b0; done_in = 3'b000;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard = 0;
    data_bus_valid = 1'b1;
    data_bus_in    = b;
    @(negedge clk);
    while (!bus_ready && guard < 200) begin
      next_cycle();
      @(negedge clk);
      guard++;
    end
    if (!bus_ready) check("byte_accept_timeout", 1'b0, 1'b1);
    next_cycle();
    data_bus_valid = 1'b0;
    data_bus_in    = 8'($urandom);
    if (gap) next_cycle();
  endtask

  // Returns at the drive point of the cycle after the last byte transfer.
  task automatic send_frame(input logic [7:0] hdr, input logic [ADDRW-1:0] src,
                            input logic [ADDRW-1:0] dst, input bit gap);
    send_byte(hdr, gap);
    for (int i = AB - 1; i >= 0; i--) send_byte(src[8*i +: 8], gap);
    for (int i = AB - 1; i >= 0; i--) send_byte(dst[8*i +: 8], gap && (i != 0));
  endtask

  task automatic check_req(input string tag, input logic [1:0] t, input logic [OPCODEW-1:0] o,
                           input logic [ADDRW-1:0] s, input logic [ADDRW-1:0] d);
    check({tag, "_valid"}, req_valid, 1'b1);
    check({tag, "_bus_ready"}, bus_ready, 1'b0);
    check({tag, "_target"}, req_target, t);
    check({tag, "_opcode"}, req_opcode, o);
    check({tag, "_src"}, req_src_addr, s);
    check({tag, "_dst"}, req_dst_addr, d);
  endtask

  // Called at the first ISSUE drive point; holds ready low for 'hold' cycles.
  task automatic expect_issue(input string tag, input logic [1:0] t, input logic [OPCODEW-1:0] o,
                              input logic [ADDRW-1:0] s, input logic [ADDRW-1:0] d, input int hold);
    req_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_req({tag, "_hold"}, t, o, s, d);
      next_cycle();
    end
    req_ready = 1'b1;
    @(negedge clk);
    check_req(tag, t, o, s, d);
    next_cycle();
    req_ready = 1'b0;
    @(negedge clk);
    check({tag, "_after_valid"}, req_valid, 1'b0);
    check({tag, "_after_ready"}, bus_ready, 1'b1);
    check({tag, "_after_state"}, state_dbg, 2'd0);
    next_cycle();
  endtask

  task automatic pulse_done(input string tag, input logic [2:0] mask, input logic [2:0] exp_ack);
    done_in = mask;
    @(negedge clk);
    check({tag, "_ack_same_cycle"}, ack_out, 3'b000);
    next_cycle();
    done_in = 3'b000;
    @(negedge clk);
    check({tag, "_ack"}, ack_out, exp_ack);
    next_cycle();
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, ack_out, 3'b000);
    next_cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]         hdr;
    logic [ADDRW-1:0]   src;
    logic [ADDRW-1:0]   dst;
    bit                 gap;
    int                 hold;
    bit                 err;
    logic [1:0]         tgt;
    logic [OPCODEW-1:0] op;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] h, input logic [ADDRW-1:0] s,
                              input logic [ADDRW-1:0] d, input bit g, input int hd,
                              input bit e, input logic [1:0] t, input logic [OPCODEW-1:0] o);
    vec_t v;
    v.hdr = h; v.src = s; v.dst = d; v.gap = g; v.hold = hd; v.err = e; v.tgt = t; v.op = o;
    return v;
  endfunction

  vec_t vecs[6];

  // ---------------- scoreboard state for random traffic ----------------
  logic [REQW-1:0] exp_q[$];
  logic [7:0]      tx_q[$];
  logic [7:0]      rx_q[$];
  logic [2:0]      outstanding;
  logic [2:0]      exp_ack;

  task automatic gen_frame();
    logic [7:0] h;
    h = 8'($urandom);
    tx_q.push_back(h);
    for (int i = 0; i < 2 * AB; i++) tx_q.push_back(8'($urandom));
  endtask

  // A completed frame decodes to {target, opcode, src, dst} by plain arithmetic.
  function automatic logic [REQW-1:0] decode_rx();
    longint unsigned s = 0, d = 0;
    int t, o;
    t = int'(rx_q[0]) / 64;
    o = (int'(rx_q[0]) / 16) % (1 << OPCODEW);
    for (int i = 1; i <= AB; i++) s = s * 256 + longint'(rx_q[i]);
    for (int i = AB + 1; i <= 2 * AB; i++) d = d * 256 + longint'(rx_q[i]);
    return {2'(t), OPCODEW'(o), ADDRW'(s), ADDRW'(d)};
  endfunction

  initial begin
    int k_err;
    int n_req;
    int n_errs;

    vecs[0] = mk(8'h50, 24'h123456, 24'hABCDEF, 1'b0, 0, 1'b0, 2'd1, 2'd1);
    vecs[1] = mk(8'hC0, 24'h111111, 24'h222222, 1'b0, 0, 1'b1, 2'd3, 2'd0);
    vecs[2] = mk(8'h8F, 24'hA5A5A5, 24'h5A5A5A, 1'b1, 5, 1'b0, 2'd2, 2'd0);
    vecs[3] = mk(8'h3A, 24'h000001, 24'hFFFFFF, 1'b1, 2, 1'b0, 2'd0, 2'd3);
    vecs[4] = mk(8'hF0, 24'h0F0F0F, 24'hF0F0F0, 1'b1, 0, 1'b1, 2'd3, 2'd3);
    vecs[5] = mk(8'h6B, 24'hFEDCBA, 24'h012345, 1'b0, 1, 1'b0, 2'd1, 2'd2);

    // Reset state
    rst = 1'b1;
    data_bus_valid = 1'b0; data_bus_in = 8'h00; req_ready = 1'b0; done_in = 3'b000;
    @(negedge clk);
    check("rst_bus_ready", bus_ready, 1'b1);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_ack", ack_out, 3'b000);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_payload", {req_target, req_opcode, req_src_addr, req_dst_addr}, '0);
    check("rst_state", state_dbg, 2'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Table-driven frames; every issued request is retired with a done pulse
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].hdr, vecs[i].src, vecs[i].dst, vecs[i].gap);
      if (vecs[i].err) begin
        @(negedge clk);
        check($sformatf("vec%0d_frame_err", i), frame_err, 1'b1);
        check($sformatf("vec%0d_no_valid", i), req_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        check($sformatf("vec%0d_err_one_cycle", i), frame_err, 1'b0);
        check($sformatf("vec%0d_next_hdr_ready", i), bus_ready, 1'b1);
        check($sformatf("vec%0d_state_hdr", i), state_dbg, 2'd0);
        next_cycle();
      end else begin
        expect_issue($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].op, vecs[i].src,
                     vecs[i].dst, vecs[i].hold);
        pulse_done($sformatf("vec%0d_done", i), 3'(1 << vecs[i].tgt), 3'(1 << vecs[i].tgt));
      end
    end

    // Back-to-back frames to engine 0: second one stalls until done_in[0]
    send_frame(8'h10, 24'h010203, 24'h040506, 1'b0);
    expect_issue("b2b_first", 2'd0, 2'd1, 24'h010203, 24'h040506, 0);
    send_frame(8'h20, 24'h0A0B0C, 24'h0D0E0F, 1'b0);
    req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("b2b_stall_valid", req_valid, 1'b0);
      check("b2b_stall_ready", bus_ready, 1'b0);
      next_cycle();
    end
    done_in = 3'b001;
    @(negedge clk);
    check("b2b_no_same_cycle_valid", req_valid, 1'b0);
    next_cycle();
    done_in = 3'b000;
    @(negedge clk);
    check("b2b_ack", ack_out, 3'b001);
    check_req("b2b_second", 2'd0, 2'd2, 24'h0A0B0C, 24'h0D0E0F);
    next_cycle();
    req_ready = 1'b0;
    @(negedge clk);
    check("b2b_ack_one_cycle", ack_out, 3'b000);
    check("b2b_state_hdr", state_dbg, 2'd0);
    next_cycle();
    pulse_done("b2b_done", 3'b001, 3'b001);

    // Simultaneous completions and a stray done on an idle engine
    send_frame(8'h00, 24'h111111, 24'h222222, 1'b0);
    expect_issue("multi_t0", 2'd0, 2'd0, 24'h111111, 24'h222222, 0);
    send_frame(8'h80, 24'h333333, 24'h444444, 1'b0);
    expect_issue("multi_t2", 2'd2, 2'd0, 24'h333333, 24'h444444, 0);
    pulse_done("multi_101", 3'b101, 3'b101);
    pulse_done("stray_010", 3'b010, 3'b000);

    // Reset in the middle of a frame while engine 1 is busy
    send_frame(8'h40, 24'hCAFE01, 24'hBEEF02, 1'b0);
    expect_issue("prerst", 2'd1, 2'd0, 24'hCAFE01, 24'hBEEF02, 0);
    send_byte(8'h80, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bus_ready", bus_ready, 1'b1);
    check("midrst_outputs", {req_valid, ack_out, frame_err}, '0);
    check("midrst_payload", {req_target, req_opcode, req_src_addr, req_dst_addr}, '0);
    check("midrst_state", state_dbg, 2'd0);
    next_cycle();
    rst = 1'b0;
    send_frame(8'h7C, 24'h13579B, 24'h2468AC, 1'b1);
    expect_issue("postrst", 2'd1, 2'd3, 24'h13579B, 24'h2468AC, 0);
    pulse_done("postrst_done", 3'b010, 3'b010);

    // Stalled partial frame: header plus one source byte, then silence
    send_byte(8'h60, 1'b0);
    send_byte(8'hAA, 1'b0);
`ifdef FRAME_TIMEOUT_EN
    k_err = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (frame_err) begin
        k_err = k;
        break;
      end
      next_cycle();
    end
    check("timeout_idle_cycles", k_err, TIMEOUT_CYCLES);
    next_cycle();
    @(negedge clk);
    check("timeout_err_one_cycle", frame_err, 1'b0);
    check("timeout_state_hdr", state_dbg, 2'd0);
    next_cycle();
    send_frame(8'h60, 24'hAABBCC, 24'h010203, 1'b0);
    expect_issue("after_timeout", 2'd1, 2'd2, 24'hAABBCC, 24'h010203, 0);
`else
    k_err = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (frame_err) k_err++;
      next_cycle();
    end
    check("no_timeout_err", k_err, 0);
    @(negedge clk);
    check("no_timeout_state_src", state_dbg, 2'd1);
    next_cycle();
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    for (int i = AB - 1; i >= 0; i--) send_byte(8'(i + 1), 1'b0);
    expect_issue("resumed", 2'd1, 2'd2, 24'hAABBCC, 24'h030201, 0);
`endif
    pulse_done("final_done", 3'b010, 3'b010);

    // Randomized traffic against the transaction-level model
    do_reset();
    outstanding = 3'b000;
    exp_ack     = 3'b000;
    n_req       = 0;
    n_errs      = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic            issuing, xfer, hs, exp_v;
      logic [REQW-1:0] cur;
      logic [1:0]      t;
      logic [2:0]      new_ack;
      if (tx_q.size() == 0) gen_frame();
      data_bus_valid = ($urandom_range(0, 3) != 0);
      data_bus_in    = data_bus_valid ? tx_q[0] : 8'($urandom);
      req_ready      = 1'($urandom_range(0, 1));
      done_in        = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      @(negedge clk);
      check("rnd_ack", ack_out, exp_ack);
      hs      = 1'b0;
      t       = 2'd0;
      issuing = (exp_q.size() != 0);
      if (issuing) begin
        cur = exp_q[0];
        t   = cur[REQW-1 -: 2];
        check("rnd_bus_ready_issue", bus_ready, 1'b0);
        if (t == 2'd3) begin
          check("rnd_frame_err", frame_err, 1'b1);
          check("rnd_err_no_valid", req_valid, 1'b0);
          void'(exp_q.pop_front());
          n_errs++;
        end else begin
          exp_v = !outstanding[t];
          check("rnd_valid", req_valid, exp_v);
          if (exp_v && req_ready) begin
            check("rnd_req", {req_target, req_opcode, req_src_addr, req_dst_addr}, cur);
            hs = 1'b1;
            void'(exp_q.pop_front());
            n_req++;
          end
        end
      end else begin
        check("rnd_idle_valid", req_valid, 1'b0);
        check("rnd_idle_err", frame_err, 1'b0);
        check("rnd_bus_ready", bus_ready, 1'b1);
      end
      xfer = data_bus_valid && !issuing;
      if (xfer) begin
        rx_q.push_back(tx_q.pop_front());
        if (rx_q.size() == 1 + 2 * AB) begin
          exp_q.push_back(decode_rx());
          rx_q.delete();
        end
      end
      new_ack     = done_in & outstanding;
      outstanding = (outstanding & ~done_in) | (hs ? 3'(1 << t) : 3'b000);
      exp_ack     = new_ack;
      next_cycle();
    end
    check("rnd_requests_seen", n_req > 20, 1'b1);
    check("rnd_errors_seen", n_errs > 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
